nv_ram_rwsp_param: RTL and testbench

NV_RAM_RWSP_PARAM -- requirements
Module: nv_ram_rwsp_param

---
 rtl/nv_ram_pkg.sv | 20 ++
 rtl/nv_ram_init_seq.sv | 63 ++++++
 rtl/nv_ram_rwsp_param.sv | 114 +++++++++++
 tb/tb_nv_ram_rwsp_param.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nv_ram_pkg.sv
// Shared types for the masked two-port RAM with clear sequencer.
// Sequencer state encoding and lane-count helper.
package nv_ram_pkg;

  localparam logic ENC_INIT  = 1'b0;
  localparam logic ENC_READY = 1'b1;

  typedef enum logic [0:0] {
    ST_INIT  = ENC_INIT,
    ST_READY = ENC_READY
  } seq_st_e;

  function automatic int calc_nl(
    input int dw,
    input int lane
  );
    return dw / lane;
  endfunction

endpackage

// File: rtl/nv_ram_init_seq.sv
// Clear sequencer: walks every entry once writing the init value,
// then idles in READY until a clear request restarts it.
module nv_ram_init_seq
  import nv_ram_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_clr,
  output logic          o_init_we,
  output logic [AW-1:0] o_init_addr,
  output logic          o_init_busy
);

  seq_st_e       r_state;
  seq_st_e       w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;
  logic          w_last;

  assign w_last = (r_cnt == AW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_INIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_last) begin
          w_state_nxt = ST_READY;
          w_cnt_nxt   = '0;
        end
      end
      ST_READY: begin
        if (i_clr) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_init_we   = (r_state == ST_INIT);
  assign o_init_busy = (r_state == ST_INIT);
  assign o_init_addr = r_cnt;

endmodule

// File: rtl/nv_ram_rwsp_param.sv
// Masked 1R1W RAM with registered read, output register and
// self-clearing array; collision read is write-first when BYPASS=1.
module nv_ram_rwsp_param
  import nv_ram_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int LANE  = 8,
  parameter int BYPASS = 1,
  parameter logic [DW-1:0] INIT_VAL = '0,
  localparam int NL = calc_nl(DW, LANE)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW-1:0] ra,
  input  logic          re,
  input  logic          ore,
  output logic [DW-1:0] dout,
  input  logic [AW-1:0] wa,
  input  logic          we,
  input  logic [NL-1:0] wmask,
  input  logic [DW-1:0] di,
  input  logic          clr,
  output logic          init_busy,
  output logic          err_acc,
  input  logic [31:0]   pwrbus_ram_pd
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_q;
  logic [DW-1:0] r_dout;
  logic          r_err;

  logic          w_init_we;
  logic [AW-1:0] w_init_addr;
  logic          w_busy;
  logic          w_ra_ok;
  logic          w_wa_ok;
  logic          w_clr_go;
  logic [DW-1:0] w_rd_old;
  logic [DW-1:0] w_rd_nxt;
  logic          w_unused;

  assign w_unused = ^pwrbus_ram_pd;

  nv_ram_init_seq #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_init_seq (
    .clk         (clk),
    .rstn        (rstn),
    .i_clr       (clr),
    .o_init_we   (w_init_we),
    .o_init_addr (w_init_addr),
    .o_init_busy (w_busy)
  );

  assign w_ra_ok  = ({1'b0, ra} < DEPTH_W);
  assign w_wa_ok  = ({1'b0, wa} < DEPTH_W);
  assign w_clr_go = clr & ~w_busy;
  assign w_rd_old = w_ra_ok ? r_mem[ra] : INIT_VAL;

  always_comb begin
    w_rd_nxt = w_rd_old;
    if (BYPASS != 0 && we && w_wa_ok && wa == ra) begin
      for (int i = 0; i < NL; i++) begin
        if (wmask[i]) begin
          w_rd_nxt[i*LANE +: LANE] = di[i*LANE +: LANE];
        end
      end
    end
  end

  // Array has no reset; it is defined only by the clear walk.
  always_ff @(posedge clk) begin
    if (w_init_we) begin
      r_mem[w_init_addr] <= INIT_VAL;
    end else if (we && w_wa_ok) begin
      for (int i = 0; i < NL; i++) begin
        if (wmask[i]) begin
          r_mem[wa][i*LANE +: LANE] <= di[i*LANE +: LANE];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_q <= '0;
      r_dout <= '0;
      r_err  <= 1'b0;
    end else begin
      if (re && !w_busy) begin
        r_rd_q <= w_rd_nxt;
      end
      if (ore) begin
        r_dout <= r_rd_q;
      end
      if (w_busy && (re || we)) begin
        r_err <= 1'b1;
      end else if (w_clr_go) begin
        r_err <= 1'b0;
      end
    end
  end

  assign dout      = r_dout;
  assign init_busy = w_busy;
  assign err_acc   = r_err;

endmodule

// File: tb/tb_nv_ram_rwsp_param.sv
// Directed plus random checks of nv_ram_rwsp_param against an
// array-level reference model.
module tb_nv_ram_rwsp_param;

  localparam int DEPTH  = 256;
  localparam int BYPASS = 1;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  ra;
  logic        re;
  logic        ore;
  logic [15:0] dout;
  logic [7:0]  wa;
  logic        we;
  logic [1:0]  wmask;
  logic [15:0] di;
  logic        clr;
  logic        init_busy;
  logic        err_acc;
  logic [31:0] pwrbus_ram_pd;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_mem [DEPTH];
  logic [15:0] m_rdq;
  logic [15:0] m_dout;
  logic        m_err;
  int          m_busy;

  nv_ram_rwsp_param u_dut (
    .clk           (clk),
    .rstn          (rstn),
    .ra            (ra),
    .re            (re),
    .ore           (ore),
    .dout          (dout),
    .wa            (wa),
    .we            (we),
    .wmask         (wmask),
    .di            (di),
    .clr           (clr),
    .init_busy     (init_busy),
    .err_acc       (err_acc),
    .pwrbus_ram_pd (pwrbus_ram_pd)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] merge(
    input logic [15:0] o,
    input logic [15:0] n,
    input logic [1:0]  m
  );
    logic [15:0] r;
    r = o;
    for (int i = 0; i < 2; i++)
      if (m[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  task automatic m_reset();
    m_busy = DEPTH;
    m_rdq  = '0;
    m_dout = '0;
    m_err  = 1'b0;
  endtask

  task automatic step();
    logic [15:0] old;
    logic [15:0] nd;
    @(posedge clk);
    if (!rstn) begin
      m_reset();
    end else begin
      nd = ore ? m_rdq : m_dout;
      if (m_busy > 0) begin
        if (re || we) m_err = 1'b1;
        m_mem[DEPTH - m_busy] = '0;
        m_busy--;
      end else begin
        old = m_mem[ra];
        if (re)
          m_rdq = (BYPASS != 0 && we && wa == ra)
                  ? merge(old, di, wmask) : old;
        if (we) m_mem[wa] = merge(m_mem[wa], di, wmask);
        if (clr) begin
          m_busy = DEPTH;
          m_err  = 1'b0;
        end
      end
      m_dout = nd;
    end
    #1;
    chk("dout", 32'(dout), 32'(m_dout));
    chk("busy", 32'(init_busy), 32'(m_busy > 0));
    chk("err", 32'(err_acc), 32'(m_err));
  endtask

  task automatic idle();
    re = 0; we = 0; ore = 0; clr = 0;
  endtask

  task automatic run_clear(input string tag);
    int n;
    n = 0;
    while (init_busy === 1'b1 && n < 300) begin
      step();
      we = 1'b0;
      n++;
    end
    chk(tag, 32'(n), 32'(DEPTH));
  endtask

  task automatic wr(
    input logic [7:0]  a,
    input logic [15:0] d,
    input logic [1:0]  m
  );
    we = 1; wa = a; di = d; wmask = m;
    step();
    we = 0;
  endtask

  task automatic rd(input logic [7:0] a);
    re = 1; ra = a;
    step();
    re = 0; ore = 1;
    step();
    ore = 0;
  endtask

  initial begin
    logic [15:0] prev;
    rstn = 0; ra = 0; wa = 0; di = 0; wmask = 0;
    pwrbus_ram_pd = $urandom;
    idle();
    m_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    #1;
    chk("rst_busy", 32'(init_busy), 32'd1);
    chk("rst_dout", 32'(dout), 32'd0);
    repeat (3) step();
    rstn = 1;
    run_clear("init_len");

    rd(8'h00);
    chk("rd00", 32'(dout), 32'h0000);
    rd(8'hFF);
    chk("rdFF", 32'(dout), 32'h0000);

    wr(8'h12, 16'hABCD, 2'b01);
    rd(8'h12);
    chk("mask_lo", 32'(dout), 32'h00CD);

    wr(8'h40, 16'h1111, 2'b11);
    re = 1; ra = 8'h40;
    we = 1; wa = 8'h40; di = 16'h2222; wmask = 2'b11;
    step();
    idle(); ore = 1;
    step();
    ore = 0;
    chk("collide", 32'(dout),
        BYPASS != 0 ? 32'h2222 : 32'h1111);

    wr(8'h33, 16'hBEEF, 2'b11);
    prev = dout;
    re = 1; ra = 8'h33;
    step();
    re = 0;
    step();
    chk("ore_hold1", 32'(dout), 32'(prev));
    step();
    chk("ore_hold2", 32'(dout), 32'(prev));
    ore = 1;
    step();
    ore = 0;
    chk("ore_late", 32'(dout), 32'hBEEF);

    wr(8'h07, 16'h5A5A, 2'b11);
    rd(8'h07);
    chk("rd07", 32'(dout), 32'h5A5A);
    clr = 1;
    step();
    clr = 0;
    we = 1; wa = 8'h07; di = 16'hFFFF; wmask = 2'b11;
    run_clear("clr_len");
    chk("err_set", 32'(err_acc), 32'd1);
    rd(8'h07);
    chk("rd07_clr", 32'(dout), 32'h0000);
    clr = 1;
    step();
    clr = 0;
    chk("err_clr", 32'(err_acc), 32'd0);
    run_clear("clr2_len");

    wr(8'h03, 16'h1234, 2'b11);
    rd(8'h03);
    chk("rd03", 32'(dout), 32'h1234);
    clr = 1;
    step();
    clr = 0;
    repeat (100) step();
    rstn = 0;
    m_reset();
    #1;
    chk("mid_dout", 32'(dout), 32'd0);
    chk("mid_busy", 32'(init_busy), 32'd1);
    repeat (2) step();
    rstn = 1;
    run_clear("restart_len");
    rd(8'h03);
    chk("rd03_clr", 32'(dout), 32'h0000);

    for (int c = 0; c < 3000; c++) begin
      re    = 1'($urandom);
      we    = 1'($urandom);
      ore   = 1'($urandom);
      clr   = ($urandom % 500) == 0;
      ra    = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom % 16);
      wa    = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom % 16);
      di    = 16'($urandom);
      wmask = 2'($urandom);
      step();
    end
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
